// File: rtl/seq_mul8_shift_add.sv
// seq_mul8_shift_add: sequential 8x8 unsigned shift-add multiplier around one Adder16bit; ports clk, rst (async high), start, a, b -> busy, done, product, ovf; SEQ_MUL_ACCUM_EN selects multiply-accumulate
module Adder16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [16:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[16];
endmodule

module seq_mul8_shift_add #(
  parameter int OPW       = 8,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic             busy,
  output logic             done,
  output logic [2*OPW-1:0] product,
  output logic             ovf
);
  localparam int W = 2 * OPW;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state;
  logic [W-1:0] acc, mcand, sum, nxt_acc, init;
  logic [OPW-1:0] mplr;
  logic [3:0] cnt;
  logic last;
`ifdef SEQ_MUL_ACCUM_EN
  logic cout;
  Adder16bit u_add (.a(acc), .b(mcand), .cin(1'b0), .sum(sum), .cout(cout));
  assign init = product;
`else
  Adder16bit u_add (.a(acc), .b(mcand), .cin(1'b0), .sum(sum), .cout());
  assign init = '0;
  assign ovf  = 1'b0;
`endif
  assign nxt_acc = mplr[0] ? sum : acc;
  // stop after the last bit, or early once no set multiplier bits remain
  assign last = (cnt == 4'(OPW - 1)) || (SKIP_ZERO && mplr[OPW-1:1] == '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SEQ_MUL_ACCUM_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          acc   <= nxt_acc;
          mcand <= {mcand[W-2:0], 1'b0};
          mplr  <= mplr >> 1;
          cnt   <= cnt + 4'd1;
`ifdef SEQ_MUL_ACCUM_EN
          ovf   <= ovf | (mplr[0] & cout);
`endif
          if (last) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= nxt_acc;
            state   <= FIN;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            mcand <= {{OPW{1'b0}}, a};
            mplr  <= b;
            cnt   <= '0;
            acc   <= init;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SEQ_MUL_ACCUM_EN
            ovf   <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mul8_shift_add.sv
// tb_seq_mul8_shift_add: directed-vector bench for seq_mul8_shift_add (early-exit and fixed-length instances)
module tb_seq_mul8_shift_add;
  logic clk = 1'b0;
  logic rst, start;
  logic [7:0] a, b;
  logic busy_z, done_z, ovf_z, busy_n, done_n, ovf_n;
  logic [15:0] product_z, product_n, mdl;
  int errs = 0;
  int checks = 0;
`ifdef SEQ_MUL_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  seq_mul8_shift_add #(.OPW(8), .SKIP_ZERO(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy_z), .done(done_z), .product(product_z), .ovf(ovf_z)
  );
  seq_mul8_shift_add #(.OPW(8), .SKIP_ZERO(1'b0)) u_nsk (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy_n), .done(done_n), .product(product_n), .ovf(ovf_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mdl = 16'h0;
  endtask

  // issue one op to both instances; ab is the hand-computed a*b, n the early-exit iteration count
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] ab, input int n);
    logic [16:0] tot;
    logic [15:0] p_z, p_n;
    logic o_z, o_n;
    int n_z, n_n, h_z, h_n;
    tot = (ACC_EN ? {1'b0, mdl} : 17'd0) + {1'b0, ab};
    n_z = 0; n_n = 0; h_z = 0; h_n = 0;
    p_z = '0; p_n = '0; o_z = 1'b0; o_n = 1'b0;
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_skip", busy_z, 1);
    check("busy_full", busy_n, 1);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (done_z) begin
        h_z++;
        if (n_z == 0) begin n_z = c; p_z = product_z; o_z = ovf_z; end
      end
      if (done_n) begin
        h_n++;
        if (n_n == 0) begin n_n = c; p_n = product_n; o_n = ovf_n; end
      end
    end
    check("lat_skip", n_z, n);
    check("prod_skip", p_z, tot[15:0]);
    check("ovf_skip", o_z, tot[16] & ACC_EN);
    check("pulse_skip", h_z, 1);
    check("lat_full", n_n, 8);
    check("prod_full", p_n, tot[15:0]);
    check("ovf_full", o_n, tot[16] & ACC_EN);
    check("pulse_full", h_n, 1);
    mdl = tot[15:0];
  endtask

  initial begin
    int c;
    logic seen;
    logic [16:0] tot;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; mdl = 16'h0;
    #12;
    check("rst_busy", busy_z, 0);
    check("rst_done", done_z, 0);
    check("rst_prod", product_z, 0);
    check("rst_ovf", ovf_z, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_op(8'hFF, 8'hFF, 16'hFE01, 8);
    run_op(8'd13, 8'd5, 16'd65, 3);
    run_op(8'd77, 8'd0, 16'd0, 1);
    run_op(8'd200, 8'd1, 16'd200, 1);
    run_op(8'd1, 8'h80, 16'd128, 8);
    run_op(8'd0, 8'hFF, 16'd0, 8);
    // start held through RUN with changing operands, then back-to-back from FIN
    a = 8'd3; b = 8'd7; start = 1'b1;
    @(posedge clk);
    #1;
    c = 0;
    while (!done_z && c < 12) begin
      a = 8'(c * 37 + 11); b = 8'(c * 53 + 5);
      @(posedge clk);
      #1 c++;
    end
    tot = (ACC_EN ? {1'b0, mdl} : 17'd0) + 17'd21;
    check("held_lat", c, 3);
    check("held_prod", product_z, tot[15:0]);
    mdl = tot[15:0];
    a = 8'd9; b = 8'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_busy", busy_z, 1);
    check("b2b_done", done_z, 0);
    c = 0;
    while (!done_z && c < 12) begin
      @(posedge clk);
      #1 c++;
    end
    tot = (ACC_EN ? {1'b0, mdl} : 17'd0) + 17'd81;
    check("b2b_lat", c, 4);
    check("b2b_prod", product_z, tot[15:0]);
    repeat (6) @(posedge clk);
    #1 do_reset();
    // async reset in iteration 4 of 200*100
    run_op(8'd2, 8'd2, 16'd4, 2);
    a = 8'd200; b = 8'd100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_busy", busy_z, 0);
    check("abort_done", done_z, 0);
    check("abort_prod", product_z, 0);
    check("abort_ovf", ovf_z, 0);
    check("abort_prod_full", product_n, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    mdl = 16'h0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 seen = seen | done_z | done_n;
    end
    check("abort_no_done", seen, 0);
    run_op(8'd2, 8'd3, 16'd6, 2);
    do_reset();
    run_op(8'hFF, 8'hFF, 16'hFE01, 8);
    run_op(8'hFF, 8'hFF, 16'hFE01, 8);
    run_op(8'd1, 8'd1, 16'd1, 1);
`ifdef SEQ_MUL_ACCUM_EN
    check("mac_final", product_z, 16'hFC03);
`else
    check("mul_final", product_z, 16'h0001);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
